// File: rtl/cfg_bank_readback.sv
// Configuration-memory readback sequencer: strobes each wordline, captures the bitline row and
// streams it as OUT_W-bit words. Optional trailing CRC-32 word when CFG_READBACK_CRC_EN is defined.
module cfg_bank_readback #(
    parameter int unsigned BL_WIDTH = 514,
    parameter int unsigned WL_COUNT = 407,
    parameter int unsigned OUT_W    = 32,
    parameter int unsigned READ_LAT = 1,
    localparam int unsigned AW      = (WL_COUNT > 1) ? $clog2(WL_COUNT) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                wl_en,
    output logic [AW-1:0]       wl_addr,
    input  logic [BL_WIDTH-1:0] bl_rdata,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last
);
    localparam int unsigned WPR = (BL_WIDTH + OUT_W - 1) / OUT_W;
    localparam int unsigned KW  = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int unsigned LW  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int unsigned RW  = WPR * OUT_W;

    typedef enum logic [2:0] {StIdle, StStrobe, StWait, StSend, StCrc, StFinal} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     r_q, r_d;
    logic [KW-1:0]     k_q, k_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic [RW-1:0]     row_q, row_d;
    logic [OUT_W-1:0]  word_q;
    logic              row_last, word_last;

    logic              busy_d, done_d, wl_en_d, out_valid_d, out_last_d;
    logic [AW-1:0]     wl_addr_d;
    logic [OUT_W-1:0]  out_data_d;

`ifdef CFG_READBACK_CRC_EN
    logic [31:0] crc_q, crc_d;

    // MSB-first, non-reflected CRC-32 over one output word.
    function automatic logic [31:0] crc32_word(input logic [31:0] crc,
                                               input logic [OUT_W-1:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = int'(OUT_W) - 1; i >= 0; i--) begin
            if (c[31] ^ data[i]) c = (c << 1) ^ 32'h04C11DB7;
            else                 c = c << 1;
        end
        return c;
    endfunction
`endif

    assign word_q    = row_q[k_q*OUT_W +: OUT_W];
    assign row_last  = (r_q == AW'(WL_COUNT - 1));
    assign word_last = (k_q == KW'(WPR - 1));

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        k_d     = k_q;
        lat_d   = lat_q;
        row_d   = row_q;
`ifdef CFG_READBACK_CRC_EN
        crc_d   = crc_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    r_d     = '0;
                    state_d = StStrobe;
`ifdef CFG_READBACK_CRC_EN
                    crc_d   = 32'hFFFF_FFFF;
`endif
                end
            end
            StStrobe: begin
                lat_d   = LW'(READ_LAT - 1);
                state_d = StWait;
            end
            StWait: begin
                if (lat_q == '0) begin
                    row_d               = '0;
                    row_d[BL_WIDTH-1:0] = bl_rdata;
                    k_d                 = '0;
                    state_d             = StSend;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            StSend: begin
                if (out_ready) begin
`ifdef CFG_READBACK_CRC_EN
                    crc_d = crc32_word(crc_q, word_q);
`endif
                    if (word_last) begin
                        k_d = '0;
                        if (row_last) begin
`ifdef CFG_READBACK_CRC_EN
                            state_d = StCrc;
`else
                            state_d = StFinal;
`endif
                        end else begin
                            r_d     = r_q + 1'b1;
                            state_d = StStrobe;
                        end
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            StCrc: begin
                if (out_ready) state_d = StFinal;
            end
            StFinal: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output registers are loaded from next-state values so they line up with the state.
    always_comb begin
        busy_d      = (state_d == StStrobe) || (state_d == StWait) ||
                      (state_d == StSend) || (state_d == StCrc);
        done_d      = (state_d == StFinal);
        wl_en_d     = (state_d == StStrobe);
        wl_addr_d   = wl_en_d ? r_d : '0;
        out_valid_d = (state_d == StSend) || (state_d == StCrc);
        out_data_d  = '0;
        out_last_d  = 1'b0;
        if (state_d == StSend) begin
            out_data_d = row_d[k_d*OUT_W +: OUT_W];
`ifndef CFG_READBACK_CRC_EN
            out_last_d = (k_d == KW'(WPR - 1)) && (r_d == AW'(WL_COUNT - 1));
`endif
        end
`ifdef CFG_READBACK_CRC_EN
        if (state_d == StCrc) begin
            out_data_d = OUT_W'(crc_d);
            out_last_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            r_q       <= '0;
            k_q       <= '0;
            lat_q     <= '0;
            row_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wl_en     <= 1'b0;
            wl_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
`ifdef CFG_READBACK_CRC_EN
            crc_q     <= 32'hFFFF_FFFF;
`endif
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            k_q       <= k_d;
            lat_q     <= lat_d;
            row_q     <= row_d;
            busy      <= busy_d;
            done      <= done_d;
            wl_en     <= wl_en_d;
            wl_addr   <= wl_addr_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_last  <= out_last_d;
`ifdef CFG_READBACK_CRC_EN
            crc_q     <= crc_d;
`endif
        end
    end
endmodule

// File: tb/tb_cfg_bank_readback.sv
// Scoreboard bench for cfg_bank_readback with a small 40x3 configuration (plus a READ_LAT=3 copy).
module tb_cfg_bank_readback;
    localparam int unsigned BLW = 40;
    localparam int unsigned WLC = 3;
    localparam int unsigned OW  = 32;
`ifdef CFG_READBACK_CRC_EN
    localparam int STREAM_CYC = 13;
`else
    localparam int STREAM_CYC = 12;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, start, out_ready, busy, done, wl_en, out_valid, out_last;
    logic [1:0]     wl_addr;
    logic [BLW-1:0] bl_rdata;
    logic [OW-1:0]  out_data;

    logic           rst3, start3, busy3, done3, wl_en3, out_valid3, out_last3;
    logic           out_ready3;
    logic [1:0]     wl_addr3;
    logic [BLW-1:0] bl_rdata3;
    logic [OW-1:0]  out_data3;

    cfg_bank_readback #(.BL_WIDTH(BLW), .WL_COUNT(WLC), .OUT_W(OW), .READ_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .wl_en(wl_en),
        .wl_addr(wl_addr), .bl_rdata(bl_rdata), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last)
    );

    cfg_bank_readback #(.BL_WIDTH(BLW), .WL_COUNT(WLC), .OUT_W(OW), .READ_LAT(3)) dut3 (
        .clk(clk), .rst(rst3), .start(start3), .busy(busy3), .done(done3), .wl_en(wl_en3),
        .wl_addr(wl_addr3), .bl_rdata(bl_rdata3), .out_data(out_data3), .out_valid(out_valid3),
        .out_ready(out_ready3), .out_last(out_last3)
    );

    // Memory models: row r returns 40'hA5_0000_0000 | r, or zero when zero_data is set.
    logic zero_data;
    always @(posedge clk) begin
        if (wl_en)  bl_rdata  <= zero_data ? '0 : {8'hA5, 32'(wl_addr)};
        if (wl_en3) bl_rdata3 <= {8'hA5, 32'(wl_addr3)};
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;
    exp_t exp_q[$];

`ifdef CFG_READBACK_CRC_EN
    function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] x;
        x = c;
        for (int i = 31; i >= 0; i--) begin
            if (x[31] ^ d[i]) x = (x << 1) ^ 32'h04C11DB7;
            else              x = x << 1;
        end
        return x;
    endfunction
`endif

    task automatic push_run(input bit zero, input int rows);
        exp_t        e;
        logic [31:0] crc;
        crc = 32'hFFFF_FFFF;
        for (int r = 0; r < rows; r++) begin
            for (int k = 0; k < 2; k++) begin
                e.data = zero ? 32'h0 : ((k == 0) ? 32'(r) : 32'h0000_00A5);
`ifdef CFG_READBACK_CRC_EN
                e.last = 1'b0;
                crc    = ref_crc(crc, e.data);
`else
                e.last = (r == WLC - 1) && (k == 1);
`endif
                exp_q.push_back(e);
            end
        end
`ifdef CFG_READBACK_CRC_EN
        if (rows == WLC) begin
            e.data = crc;
            e.last = 1'b1;
            exp_q.push_back(e);
        end
`else
        if (crc != 32'hFFFF_FFFF) $display("unexpected crc state");
`endif
    endtask

    // Monitor: pops the scoreboard on every handshake, checks holds under backpressure.
    int          hs_count = 0;
    int          last_hs_cyc = 0;
    bit          hold_v = 0, done_expect = 0;
    logic [31:0] hold_d;
    logic        hold_l;
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (hold_v) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", out_data, hold_d);
            chk("hold_last", 32'(out_last), 32'(hold_l));
            hold_v = 0;
        end
        if (done_expect) begin
            chk("done_after_last", 32'(done), 32'd1);
            chk("busy_with_done", 32'(busy), 32'd0);
            done_expect = 0;
        end
        if (out_valid) begin
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word actual=%h required=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_data", out_data, e.data);
                    chk("word_last", 32'(out_last), 32'(e.last));
                end
                hs_count++;
                if (out_last) begin
                    last_hs_cyc = cyc + 1;
                    done_expect = 1;
                end
            end else begin
                hold_v = 1;
                hold_d = out_data;
                hold_l = out_last;
            end
        end
    end

    bit toggle = 0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = toggle ? ~out_ready : 1'b1;
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_wl_en"}, 32'(wl_en), 32'd0);
        chk({tag, "_wl_addr"}, 32'(wl_addr), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, out_data, 32'd0);
        chk({tag, "_last"}, 32'(out_last), 32'd0);
    endtask

    // Entered at posedge+2; returns at posedge+2 after the block is back in IDLE.
    task automatic run(input bit zero, input bit timed, input bit restart);
        int  start_cyc;
        bit  seen;
        zero_data = zero;
        push_run(zero, WLC);
        hs_count = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
        @(negedge clk);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_wl_en", 32'(wl_en), 32'd1);
        chk("start_wl_addr", 32'(wl_addr), 32'd0);
        if (restart) begin
            seen = 0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(posedge clk);
                #2;
                if (hs_count >= 2 && out_valid) seen = 1;
            end
            chk("restart_window_found", 32'(seen), 32'd1);
            start = 1'b1;
            @(posedge clk);
            #2;
            start = 1'b0;
        end
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (timed) chk("stream_cycles", 32'(last_hs_cyc - start_cyc), 32'(STREAM_CYC));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("idle_after_done", 32'(busy | done), 32'd0);
        @(posedge clk);
        #2;
    endtask

    bit dut3_fin = 0;

    initial begin
        bit seen;
        rst = 1'b1;
        start = 1'b0;
        zero_data = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;

        run(1'b0, 1'b1, 1'b0);
        run(1'b0, 1'b1, 1'b1);

        // Reset during row 1 WAIT: only row 0 words may appear.
        push_run(1'b0, 1);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (wl_en && wl_addr == 2'd1) seen = 1;
        end
        chk("row1_strobe_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_outputs_zero("midreset");
        rst = 1'b0;
        chk("midreset_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #2;
        run(1'b0, 1'b1, 1'b0);

        toggle = 1;
        run(1'b0, 1'b0, 1'b0);
        toggle = 0;
        @(posedge clk);
        #2;

        run(1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 500 && !dut3_fin; i++) @(posedge clk);
        chk("lat3_finished", 32'(dut3_fin), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // READ_LAT=3 instance: out_valid rises 4 cycles after each wl_en, addresses 0,1,2.
    initial begin
        int exp_addr = 0, wl_cyc = 0, rises = 0;
        bit pv = 0, fin = 0;
        out_ready3 = 1'b1;
        rst3 = 1'b1;
        start3 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst3 = 1'b0;
        @(posedge clk);
        #2;
        start3 = 1'b1;
        @(posedge clk);
        #2;
        start3 = 1'b0;
        for (int i = 0; i < 100 && !fin; i++) begin
            @(negedge clk);
            if (wl_en3) begin
                chk("lat3_addr", 32'(wl_addr3), 32'(exp_addr));
                exp_addr++;
                wl_cyc = cyc;
            end
            if (out_valid3 && !pv) begin
                chk("lat3_valid_rise", 32'(cyc - wl_cyc), 32'd4);
                rises++;
            end
            pv = out_valid3;
            if (done3) fin = 1;
        end
        chk("lat3_done", 32'(fin), 32'd1);
        chk("lat3_rows", 32'(exp_addr), 32'd3);
        chk("lat3_rises", 32'(rises), 32'd3);
        dut3_fin = 1;
    end
endmodule
